// File: rtl/n2t_dmux16_stream.sv
// Ready/valid 1-to-2 demultiplexer for 16-bit words. Each output channel has
// its own 2-deep FIFO and a delivered-word counter.

module n2t_dmux16_fifo2 (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [15:0] push_data,
    input  logic        pop_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic [1:0]  level,
    output logic        popped
);

    logic [15:0] slot0_q, slot0_d;
    logic [15:0] slot1_q, slot1_d;
    logic [1:0]  level_q, level_d;
    logic        pop_s;

    assign pop_s     = (level_q != 2'd0) && pop_ready;
    assign out_valid = (level_q != 2'd0);
    assign out_data  = slot0_q;
    assign level     = level_q;
    assign popped    = pop_s;

    // slot0 is always the head, so a pop shifts slot1 forward
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        level_d = level_q;
        case ({push, pop_s})
            2'b01: begin
                slot0_d = slot1_q;
                level_d = level_q - 2'd1;
            end
            2'b10: begin
                if (level_q == 2'd0) begin
                    slot0_d = push_data;
                end else begin
                    slot1_d = push_data;
                end
                level_d = level_q + 2'd1;
            end
            2'b11: begin
                if (level_q == 2'd1) begin
                    slot0_d = push_data;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = push_data;
                end
            end
            default: begin
                level_d = level_q;
            end
        endcase
    end

    // FIFO storage and fill level
    always_ff @(posedge clk) begin
        if (reset) begin
            slot0_q <= 16'h0000;
            slot1_q <= 16'h0000;
            level_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            level_q <= level_d;
        end
    end

endmodule

module n2t_dmux16_stream (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_sel,
    output logic        a_valid,
    input  logic        a_ready,
    output logic [15:0] a_data,
    output logic        b_valid,
    input  logic        b_ready,
    output logic [15:0] b_data,
    output logic [15:0] a_count,
    output logic [15:0] b_count
);

    logic [1:0]  a_level_s, b_level_s;
    logic        a_push_s, b_push_s;
    logic        a_pop_s, b_pop_s;
    logic [15:0] a_count_q, a_count_d;
    logic [15:0] b_count_q, b_count_d;

    // Readiness comes only from registered levels, never from the consumers
    assign in_ready = in_sel ? (b_level_s != 2'd2) : (a_level_s != 2'd2);
    assign a_push_s = in_valid && in_ready && !in_sel;
    assign b_push_s = in_valid && in_ready &&  in_sel;

    n2t_dmux16_fifo2 u_fifo_a (
        .clk       (clk),
        .reset     (reset),
        .push      (a_push_s),
        .push_data (in_data),
        .pop_ready (a_ready),
        .out_valid (a_valid),
        .out_data  (a_data),
        .level     (a_level_s),
        .popped    (a_pop_s)
    );

    n2t_dmux16_fifo2 u_fifo_b (
        .clk       (clk),
        .reset     (reset),
        .push      (b_push_s),
        .push_data (in_data),
        .pop_ready (b_ready),
        .out_valid (b_valid),
        .out_data  (b_data),
        .level     (b_level_s),
        .popped    (b_pop_s)
    );

    // Delivered-word counters, wrapping naturally at 16 bits
    always_comb begin
        a_count_d = a_count_q;
        b_count_d = b_count_q;
        if (a_pop_s) begin
            a_count_d = a_count_q + 16'd1;
        end else begin
            a_count_d = a_count_q;
        end
        if (b_pop_s) begin
            b_count_d = b_count_q + 16'd1;
        end else begin
            b_count_d = b_count_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_count_q <= 16'h0000;
            b_count_q <= 16'h0000;
        end else begin
            a_count_q <= a_count_d;
            b_count_q <= b_count_d;
        end
    end

    assign a_count = a_count_q;
    assign b_count = b_count_q;

endmodule

// File: tb/tb_n2t_dmux16_stream.sv
// Scoreboard bench for n2t_dmux16_stream: per-channel expected-word queues
// plus model counters, compared against the DUT one step after each edge.

module tb_n2t_dmux16_stream;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic        in_sel = 1'b0;
    logic        a_valid;
    logic        a_ready = 1'b0;
    logic [15:0] a_data;
    logic        b_valid;
    logic        b_ready = 1'b0;
    logic [15:0] b_data;
    logic [15:0] a_count;
    logic [15:0] b_count;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] exp_a_cnt = 16'h0000;
    logic [15:0] exp_b_cnt = 16'h0000;
    int          pass_cnt = 0;
    int          chk_cnt = 0;

    n2t_dmux16_stream dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Advance one clock edge, updating the scoreboard from the driven inputs
    task automatic tick();
        bit pa, pb, acc;
        @(negedge clk);
        pa  = (qa.size() != 0) && a_ready;
        pb  = (qb.size() != 0) && b_ready;
        acc = in_valid && (in_sel ? (qb.size() < 2) : (qa.size() < 2));
        @(posedge clk);
        if (reset) begin
            qa.delete();
            qb.delete();
            exp_a_cnt = 16'h0000;
            exp_b_cnt = 16'h0000;
        end else begin
            if (pa) begin
                void'(qa.pop_front());
                exp_a_cnt = exp_a_cnt + 16'd1;
            end
            if (pb) begin
                void'(qb.pop_front());
                exp_b_cnt = exp_b_cnt + 16'd1;
            end
            if (acc) begin
                if (in_sel) qb.push_back(in_data);
                else        qa.push_back(in_data);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic drive(input bit v, input bit sel, input logic [15:0] d);
        in_valid = v; in_sel = sel; in_data = d;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h7777;
        a_ready = 1'b1; b_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0; in_valid = 1'b0;
        chk_cnt++; if (a_valid !== 1'b0) $display("FAIL rst_a_valid got=%0b exp=0", a_valid); else pass_cnt++;
        chk_cnt++; if (b_valid !== 1'b0) $display("FAIL rst_b_valid got=%0b exp=0", b_valid); else pass_cnt++;
        chk_cnt++; if (a_count !== 16'h0000) $display("FAIL rst_a_count got=%h exp=0000", a_count); else pass_cnt++;
        chk_cnt++; if (b_count !== 16'h0000) $display("FAIL rst_b_count got=%h exp=0000", b_count); else pass_cnt++;
        in_sel = 1'b0; #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready_a got=%0b exp=1", in_ready); else pass_cnt++;
        in_sel = 1'b1; #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready_b got=%0b exp=1", in_ready); else pass_cnt++;
    endtask

    task automatic test_routing();
        do_reset();
        a_ready = 1'b1; b_ready = 1'b1;
        drive(1'b1, 1'b0, 16'h1234);
        chk_cnt++; if (a_valid !== 1'b1 || a_data !== 16'h1234) $display("FAIL route_a got=%0b/%h exp=1/1234", a_valid, a_data); else pass_cnt++;
        chk_cnt++; if (b_valid !== 1'b0) $display("FAIL route_b_idle got=%0b exp=0", b_valid); else pass_cnt++;
        drive(1'b1, 1'b1, 16'hABCD);
        chk_cnt++; if (b_valid !== 1'b1 || b_data !== 16'hABCD) $display("FAIL route_b got=%0b/%h exp=1/abcd", b_valid, b_data); else pass_cnt++;
        drive(1'b0, 1'b0, 16'h0000);
        chk_cnt++; if (a_count !== 16'd1 || a_count !== exp_a_cnt) $display("FAIL route_a_count got=%0d exp=1", a_count); else pass_cnt++;
        chk_cnt++; if (b_count !== 16'd1 || b_count !== exp_b_cnt) $display("FAIL route_b_count got=%0d exp=1", b_count); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, 1'b0, 16'h0001);
        drive(1'b1, 1'b0, 16'h0002);
        in_valid = 1'b0; in_sel = 1'b0; #1;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready_full got=%0b exp=0", in_ready); else pass_cnt++;
        in_sel = 1'b1; #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_other got=%0b exp=1", in_ready); else pass_cnt++;
        drive(1'b1, 1'b0, 16'hDEAD);
        drive(1'b1, 1'b1, 16'h0003);
        in_valid = 1'b0;
        chk_cnt++; if (b_valid !== 1'b1 || b_data !== 16'h0003) $display("FAIL bp_b_accept got=%0b/%h exp=1/0003", b_valid, b_data); else pass_cnt++;
        chk_cnt++; if (a_data !== 16'h0001) $display("FAIL bp_a_head got=%h exp=0001", a_data); else pass_cnt++;
        a_ready = 1'b1;
        tick();
        chk_cnt++; if (a_valid !== 1'b1 || a_data !== 16'h0002) $display("FAIL bp_a_second got=%0b/%h exp=1/0002", a_valid, a_data); else pass_cnt++;
        tick();
        chk_cnt++; if (a_valid !== 1'b0) $display("FAIL bp_a_drained got=%0b exp=0", a_valid); else pass_cnt++;
        chk_cnt++; if (a_count !== 16'd2) $display("FAIL bp_a_count got=%0d exp=2", a_count); else pass_cnt++;
        chk_cnt++; if (b_count !== 16'd0 || b_data !== 16'h0003) $display("FAIL bp_b_untouched got=%0d/%h exp=0/0003", b_count, b_data); else pass_cnt++;
    endtask

    task automatic test_push_pop_same();
        do_reset();
        drive(1'b1, 1'b0, 16'h0010);
        a_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0011; #1;
        chk_cnt++; if (a_data !== 16'h0010) $display("FAIL pp_head_before got=%h exp=0010", a_data); else pass_cnt++;
        tick();
        in_valid = 1'b0; a_ready = 1'b0;
        chk_cnt++; if (a_valid !== 1'b1 || a_data !== 16'h0011) $display("FAIL pp_new_head got=%0b/%h exp=1/0011", a_valid, a_data); else pass_cnt++;
        chk_cnt++; if (a_count !== 16'd1) $display("FAIL pp_count got=%0d exp=1", a_count); else pass_cnt++;
        in_sel = 1'b0; #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL pp_level_one got=%0b exp=1", in_ready); else pass_cnt++;
        a_ready = 1'b1;
        tick();
        chk_cnt++; if (a_valid !== 1'b0 || a_count !== 16'd2) $display("FAIL pp_drain got=%0b/%0d exp=0/2", a_valid, a_count); else pass_cnt++;
    endtask

    task automatic test_count_wrap();
        int guard;
        do_reset();
        b_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b1;
        guard = 0;
        while (exp_b_cnt != 16'hFFFF && guard < 70000) begin
            in_data = guard[15:0];
            tick();
            guard++;
        end
        in_valid = 1'b0;
        chk_cnt++; if (b_count !== 16'hFFFF) $display("FAIL wrap_ffff got=%h exp=ffff", b_count); else pass_cnt++;
        chk_cnt++; if (b_valid !== 1'b1 || (qb.size() != 0 && b_data !== qb[0])) $display("FAIL wrap_head got=%0b/%h", b_valid, b_data); else pass_cnt++;
        tick();
        chk_cnt++; if (b_count !== 16'h0000) $display("FAIL wrap_zero got=%h exp=0000", b_count); else pass_cnt++;
        chk_cnt++; if (a_count !== 16'h0000) $display("FAIL wrap_a_count got=%h exp=0000", a_count); else pass_cnt++;
        b_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        a_ready = 1'b1; b_ready = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 16'h0A00 + 16'(i));
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 16'h0B00 + 16'(i));
        drive(1'b0, 1'b0, 16'h0000);
        a_ready = 1'b0; b_ready = 1'b0;
        drive(1'b1, 1'b0, 16'h00A1);
        drive(1'b1, 1'b0, 16'h00A2);
        drive(1'b1, 1'b1, 16'h00B1);
        drive(1'b1, 1'b1, 16'h00B2);
        chk_cnt++; if (a_count !== 16'd5 || b_count !== 16'd7) $display("FAIL mid_counts got=%0d/%0d exp=5/7", a_count, b_count); else pass_cnt++;
        in_valid = 1'b0; in_sel = 1'b0; #1;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL mid_full_a got=%0b exp=0", in_ready); else pass_cnt++;
        reset = 1'b1; in_valid = 1'b1; in_data = 16'h0BAD; a_ready = 1'b1; b_ready = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        chk_cnt++; if (a_valid !== 1'b0 || b_valid !== 1'b0) $display("FAIL mid_valids got=%0b/%0b exp=0/0", a_valid, b_valid); else pass_cnt++;
        chk_cnt++; if (a_count !== 16'd0 || b_count !== 16'd0) $display("FAIL mid_cnt_clr got=%0d/%0d exp=0/0", a_count, b_count); else pass_cnt++;
        in_sel = 1'b1; #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL mid_ready got=%0b exp=1", in_ready); else pass_cnt++;
        drive(1'b1, 1'b0, 16'h0055);
        drive(1'b1, 1'b1, 16'h0066);
        drive(1'b1, 1'b0, 16'h0056);
        in_valid = 1'b0;
        chk_cnt++; if (a_data !== 16'h0055 || b_data !== 16'h0066) $display("FAIL mid_restart got=%h/%h exp=0055/0066", a_data, b_data); else pass_cnt++;
        a_ready = 1'b1;
        tick();
        chk_cnt++; if (a_valid !== 1'b1 || a_data !== 16'h0056) $display("FAIL mid_order got=%0b/%h exp=1/0056", a_valid, a_data); else pass_cnt++;
    endtask

    task automatic test_stress();
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_sel   = 1'($urandom_range(0, 1));
            in_data  = 16'($urandom);
            a_ready  = ($urandom_range(0, 3) != 0);
            b_ready  = ($urandom_range(0, 2) == 0);
            #1;
            chk_cnt++;
            if (a_valid !== (qa.size() != 0) || (qa.size() != 0 && a_data !== qa[0]))
                $display("FAIL stress_a cyc=%0d got=%0b/%h exp=%0b/%h", i, a_valid, a_data, qa.size() != 0, (qa.size() != 0) ? qa[0] : 16'h0000);
            else pass_cnt++;
            chk_cnt++;
            if (b_valid !== (qb.size() != 0) || (qb.size() != 0 && b_data !== qb[0]))
                $display("FAIL stress_b cyc=%0d got=%0b/%h exp=%0b/%h", i, b_valid, b_data, qb.size() != 0, (qb.size() != 0) ? qb[0] : 16'h0000);
            else pass_cnt++;
            chk_cnt++;
            if (in_ready !== (in_sel ? (qb.size() < 2) : (qa.size() < 2)))
                $display("FAIL stress_ready cyc=%0d got=%0b sel=%0b", i, in_ready, in_sel);
            else pass_cnt++;
            chk_cnt++;
            if (a_count !== exp_a_cnt || b_count !== exp_b_cnt)
                $display("FAIL stress_count cyc=%0d got=%0d/%0d exp=%0d/%0d", i, a_count, b_count, exp_a_cnt, exp_b_cnt);
            else pass_cnt++;
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_push_pop_same();
        test_count_wrap();
        test_reset_mid();
        test_stress();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
